seq_run_ctl: RTL and testbench
==============================

// Module: seq_run_ctl
// PURPOSE
//  - Start/done-handshaked sequencer for the seq_gen_dp datapath (R0/R1 regs, add/sub unit, shifter).
//  - Produces a programmable number of terms N in one of two modes:
//    - Fibonacci
//    - powers of two
//  - Drives as_ctl/shift_ctl/r1_ld/r0_ld and a datapath clear each cycle.
//  - Flags each valid seq_out term to the consumer.
//  - Sits between a host-side command interface and seq_gen_dp.
// PARAMETERS
//  - CNT_W  default 8  width of n_terms and term_idx (max 2^CNT_W-1 terms per run)
// PORTS
//  - clk        in   1          single clock, all state updates on rising edge
//  - reset      in   1          synchronous, active-high; also forces dp_reset
//  - start      in   1          run request; sampled only in IDLE
//  - mode       in   1          0 = Fibonacci, 1 = powers of two; latched on start
//  - n_terms    in   CNT_W      terms to produce; latched on start
//  - pause      in   1          only with SEQ_RUN_PAUSE_EN
//  - busy       out  1          state != IDLE
//  - done       out  1          one-cycle pulse at end of run
//  - term_valid out  1          seq_out holds term term_idx this cycle
//  - term_idx   out  CNT_W      index of current term, 0-based
//  - dp_reset   out  1          to seq_gen_dp reset: reset | (state==INIT)
//  - as_ctl     out  as_ctl_t   add/sub select
//  - shift_ctl  out  shift_ctl_t shifter select
//  - r1_ld      out  1          R1 load enable
//  - r0_ld      out  1          R0 load enable
// BEHAVIOUR
//  - Datapath contract (seq_gen_dp), fixed:
//    - Clear sets R0=0, R1=1; seq_out = R1.
//    - r0_ld loads R0 <= R1.
//    - r1_ld loads R1 <= shift(R0 as R1) per shift_ctl; AS_PASS passes R1.
//    - All 16-bit, wraps mod 2^16; the controller ignores overflow.
//  - FSM states: IDLE, INIT, STEP, DONE. Reset -> IDLE, cnt=0, all outputs 0 except dp_reset=1.
//  - IDLE:
//    - Outputs low, loads off.
//    - start=1 -> INIT; latch mode and n_terms.
//  - INIT: one cycle.
//    - dp_reset=1, loads off, cnt<=0.
//    - -> STEP if n!=0, else -> DONE.
//  - STEP:
//    - term_valid=1, term_idx=cnt; loads asserted every cycle.
//    - Fibonacci: as=AS_ADD, sh=SH_NONE, r0_ld=1, r1_ld=1.
//    - Pow2: as=AS_PASS, sh=SH_LEFT, r0_ld=0, r1_ld=1.
//    - cnt==n-1 -> DONE, else cnt<=cnt+1.
//    - Final-step load is harmless.
//  - DONE:
//    - done=1 for exactly one cycle, loads off, term_valid=0.
//    - -> IDLE.
//  - Latency: first term_valid 2 cycles after start sampled; done 2+N cycles after start.
//  - busy is high in INIT/STEP/DONE. start while busy is ignored; no queuing.
//  - A new start the cycle after done is accepted, giving back-to-back runs.
//  - n_terms/mode changes while busy are ignored (latched copies used).
//  - reset mid-run: IDLE on next edge, no done pulse, dp_reset=1 that cycle.
//  - All outputs decoded combinationally from state/cnt/latched mode; no glitch-sensitive consumers.
// CONFIGURATION
//  - `define SEQ_RUN_PAUSE_EN: adds the pause input.
//    - pause=1 in STEP: loads off, term_valid=0, cnt/state held.
//    - Resume continues with the same term_idx.
//    - pause has no effect in other states.
//  - Without it: no pause port; STEP advances every cycle.
// STRUCTURE
//  - Shared package seq_pkg holds:
//    - reg16_t, as_ctl_t (AS_PASS, AS_ADD, AS_SUB), shift_ctl_t (SH_NONE, SH_LEFT, SH_RIGHT)
//    - run_state_t enum (IDLE, INIT, STEP, DONE)
//    - MODE_FIB=1'b0, MODE_POW2=1'b1
//  - One natural sub-module: seq_run_cnt (loadable CNT_W counter with clear/en and last flag).
//  - FSM and output decode live in seq_run_ctl.
// TESTING (bench instantiates seq_gen_dp + seq_run_ctl, checks seq_out when term_valid)
//  - Fibonacci, N=6: start 1 cycle -> term_valid 6 cycles; seq_out 1,1,2,3,5,8; idx 0..5; done at start+8.
//  - Pow2, N=4 -> seq_out 1,2,4,8; r0_ld never high; single done pulse; busy low after.
//  - Pow2, N=17 -> term 16 = 0x0000 (wrap), no stall.
//  - N=0 -> INIT then DONE; zero term_valid; done at start+2.
//  - start held high through a Fib N=3 run -> exactly one run per IDLE visit; back-to-back run restarts at 1.
//  - reset mid-STEP (idx=2) -> IDLE next edge, no done.
//  - reset mid-STEP, then fresh Fib N=3 -> 1,1,2.
//  - SEQ_RUN_PAUSE_EN, Fib N=5, pause 3 cycles at idx 2 -> seq_out stays 2, term_valid 0; resumes 2,3,5.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the seq_gen_dp datapath and its run controller.
package seq_pkg;

    typedef logic [15:0] reg16_t;

    typedef enum logic [1:0] {
        AS_PASS = 2'd0,
        AS_ADD  = 2'd1,
        AS_SUB  = 2'd2
    } as_ctl_t;

    typedef enum logic [1:0] {
        SH_NONE  = 2'd0,
        SH_LEFT  = 2'd1,
        SH_RIGHT = 2'd2
    } shift_ctl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam logic MODE_FIB  = 1'b0;
    localparam logic MODE_POW2 = 1'b1;

endpackage

// File: rtl/seq_run_ctl_if.sv
// Host-side command/status bundle of seq_run_ctl; pause exists only with SEQ_RUN_PAUSE_EN.
interface seq_run_ctl_if #(
    parameter int CNT_W = 8
);
`ifdef SEQ_RUN_PAUSE_EN
    logic             pause;
`endif
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] n_terms;
    logic             busy;
    logic             done;
    logic             term_valid;
    logic [CNT_W-1:0] term_idx;

    modport master (
`ifdef SEQ_RUN_PAUSE_EN
        output pause,
`endif
        output start, mode, n_terms,
        input  busy, done, term_valid, term_idx
    );

    modport slave (
`ifdef SEQ_RUN_PAUSE_EN
        input  pause,
`endif
        input  start, mode, n_terms,
        output busy, done, term_valid, term_idx
    );
endinterface

// File: rtl/seq_gen_dp.sv
// Sequence datapath: R0/R1 registers, add/sub unit and shifter; seq_out is R1.
module seq_gen_dp
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  as_ctl_t    as_ctl,
    input  shift_ctl_t shift_ctl,
    input  logic       r1_ld,
    input  logic       r0_ld,
    output reg16_t     seq_out
);
    reg16_t r0_q, r0_d;
    reg16_t r1_q, r1_d;
    reg16_t as_res;
    reg16_t sh_res;

    always_comb begin
        case (as_ctl)
            AS_ADD:  as_res = r0_q + r1_q;
            AS_SUB:  as_res = r0_q - r1_q;
            default: as_res = r1_q;
        endcase
        case (shift_ctl)
            SH_LEFT:  sh_res = as_res << 1;
            SH_RIGHT: sh_res = as_res >> 1;
            default:  sh_res = as_res;
        endcase
        r0_d = r0_ld ? r1_q : r0_q;
        r1_d = r1_ld ? sh_res : r1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r0_q <= 16'd0;
            r1_q <= 16'd1;
        end else begin
            r0_q <= r0_d;
            r1_q <= r1_d;
        end
    end

    assign seq_out = r1_q;
endmodule

// File: rtl/seq_run_cnt.sv
// Term counter: clear/enable, and a last flag when the count reaches lim-1.
module seq_run_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] lim,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == lim - CNT_W'(1));
endmodule

// File: rtl/seq_run_ctl.sv
// Start/done sequencer driving seq_gen_dp for Fibonacci or powers-of-two runs of N terms.
// Optional feature: define SEQ_RUN_PAUSE_EN to add the host pause input.
module seq_run_ctl
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    seq_run_ctl_if.slave  host,
    output logic          dp_reset,
    output as_ctl_t       as_ctl,
    output shift_ctl_t    shift_ctl,
    output logic          r1_ld,
    output logic          r0_ld
);
    run_state_t       state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_clr;
    logic             cnt_en;
    logic             stall;
    logic             stepping;

`ifdef SEQ_RUN_PAUSE_EN
    assign stall = host.pause;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    state_d = INIT;
                    mode_d  = host.mode;
                    n_d     = host.n_terms;
                end
            end
            INIT:    state_d = (n_q == '0) ? DONE : STEP;
            STEP:    if (!stall && cnt_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Mode and length are only captured on an accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
        mode_q <= mode_d;
        n_q    <= n_d;
    end

    assign cnt_clr = (state_q == INIT);
    assign cnt_en  = (state_q == STEP) && !stall && !cnt_last;

    seq_run_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (reset),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .lim  (n_q),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // While reset is asserted every output except dp_reset is forced low.
    assign stepping = !reset && (state_q == STEP) && !stall;

    always_comb begin
        as_ctl    = AS_PASS;
        shift_ctl = SH_NONE;
        r1_ld     = 1'b0;
        r0_ld     = 1'b0;
        if (stepping) begin
            r1_ld = 1'b1;
            if (mode_q == MODE_FIB) begin
                as_ctl = AS_ADD;
                r0_ld  = 1'b1;
            end else begin
                shift_ctl = SH_LEFT;
            end
        end
    end

    assign dp_reset        = reset || (state_q == INIT);
    assign host.busy       = !reset && (state_q != IDLE);
    assign host.done       = !reset && (state_q == DONE);
    assign host.term_valid = stepping;
    assign host.term_idx   = (!reset && state_q == STEP) ? cnt : '0;
endmodule

// File: tb/tb_seq_run_ctl.sv
// Bench for seq_run_ctl driving seq_gen_dp: table runs, corner sequences and random runs.
module tb_seq_run_ctl;
    import seq_pkg::*;

    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       dp_reset, r1_ld, r0_ld;
    as_ctl_t    as_ctl;
    shift_ctl_t shift_ctl;
    reg16_t     seq_out;

    int     checks = 0;
    int     errors = 0;
    int     vcnt;
    reg16_t last_seen;

    typedef struct {
        logic          m;
        int            n;
        int            exp_cnt;
        logic [15:0]   exp_last;
    } vec_t;

    vec_t tbl [7];

    seq_run_ctl_if #(.CNT_W(CNT_W)) host ();

    seq_run_ctl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (host),
        .dp_reset  (dp_reset),
        .as_ctl    (as_ctl),
        .shift_ctl (shift_ctl),
        .r1_ld     (r1_ld),
        .r0_ld     (r0_ld)
    );

    seq_gen_dp dp (
        .clk       (clk),
        .reset     (dp_reset),
        .as_ctl    (as_ctl),
        .shift_ctl (shift_ctl),
        .r1_ld     (r1_ld),
        .r0_ld     (r0_ld),
        .seq_out   (seq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Term k of a run: Fibonacci F(k+1) or 2^k, both modulo 2^16.
    function automatic logic [15:0] ref_term(input logic m, input int k);
        logic [15:0] a, b, s;
        if (m == MODE_POW2) return (k >= 16) ? 16'd0 : 16'(32'd1 << k);
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < k; i++) begin
            s = a + b;
            a = b;
            b = s;
        end
        return b;
    endfunction

    // t counts cycles after the edge that accepted start: 1 = INIT, 2..n+1 = terms, n+2 = done.
    task automatic check_phase(input string tag, input int t, input logic m, input int n);
        logic [5:0] act_f, exp_f;
        act_f = {host.busy, host.done, host.term_valid, dp_reset, r1_ld, r0_ld};
        if (t == 1) begin
            exp_f = 6'b100100;
        end else if (t <= n + 1) begin
            exp_f = {5'b10101, (m == MODE_FIB)};
            chk($sformatf("%s t%0d idx", tag, t), 32'(host.term_idx), 32'(t - 2));
            chk($sformatf("%s t%0d seq_out", tag, t), 32'(seq_out), 32'(ref_term(m, t - 2)));
            chk($sformatf("%s t%0d as_ctl", tag, t), 32'(as_ctl),
                32'((m == MODE_FIB) ? AS_ADD : AS_PASS));
            chk($sformatf("%s t%0d shift_ctl", tag, t), 32'(shift_ctl),
                32'((m == MODE_FIB) ? SH_NONE : SH_LEFT));
        end else begin
            exp_f = 6'b110000;
        end
        chk($sformatf("%s t%0d busy/done/valid/dprst/r1/r0", tag, t), 32'(act_f), 32'(exp_f));
    endtask

    task automatic check_run(input string tag, input logic m, input int n, input bit hold,
                             input int stop_at);
        for (int t = 1; t <= stop_at; t++) begin
            @(negedge clk);
            check_phase(tag, t, m, n);
            if (host.term_valid) begin
                vcnt++;
                last_seen = seq_out;
            end
            if (hold) begin
                host.start = 1'b1;
            end else if (t < n + 2) begin
                host.start   = 1'($urandom_range(0, 1));
                host.mode    = 1'($urandom);
                host.n_terms = CNT_W'($urandom);
            end else begin
                host.start   = 1'b0;
                host.mode    = 1'($urandom);
                host.n_terms = CNT_W'($urandom);
            end
        end
    endtask

    task automatic do_run(input string tag, input logic m, input int n);
        @(negedge clk);
        host.start   = 1'b1;
        host.mode    = m;
        host.n_terms = CNT_W'(n);
        vcnt         = 0;
        last_seen    = 16'hDEAD;
        check_run(tag, m, n, 1'b0, n + 2);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, " idle busy/done/valid/dprst/r1/r0"},
            32'({host.busy, host.done, host.term_valid, dp_reset, r1_ld, r0_ld}), 32'd0);
    endtask

    initial begin
        tbl[0] = '{MODE_FIB,   6,  6, 16'd8};
        tbl[1] = '{MODE_POW2,  4,  4, 16'd8};
        tbl[2] = '{MODE_POW2, 17, 17, 16'd0};
        tbl[3] = '{MODE_FIB,   0,  0, 16'hDEAD};
        tbl[4] = '{MODE_FIB,   1,  1, 16'd1};
        tbl[5] = '{MODE_FIB,  25, 25, 16'd9489};
        tbl[6] = '{MODE_POW2, 15, 15, 16'd16384};

        reset        = 1'b1;
        host.start   = 1'b0;
        host.mode    = 1'b0;
        host.n_terms = '0;
`ifdef SEQ_RUN_PAUSE_EN
        host.pause   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset busy/done/valid/dprst/r1/r0",
            32'({host.busy, host.done, host.term_valid, dp_reset, r1_ld, r0_ld}), 32'b000100);
        chk("reset term_idx", 32'(host.term_idx), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_idle("post-reset");

        for (int i = 0; i < 7; i++) begin
            do_run($sformatf("tbl%0d", i), tbl[i].m, tbl[i].n);
            chk($sformatf("tbl%0d term count", i), 32'(vcnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d last term", i), 32'(last_seen), 32'(tbl[i].exp_last));
            check_idle($sformatf("tbl%0d after", i));
        end

        // start held high: one run per IDLE visit, the next one restarts at 1
        @(negedge clk);
        host.start   = 1'b1;
        host.mode    = MODE_FIB;
        host.n_terms = CNT_W'(3);
        check_run("hold1", MODE_FIB, 3, 1'b1, 5);
        check_idle("hold gap");
        check_run("hold2", MODE_FIB, 3, 1'b1, 5);
        host.start = 1'b0;
        check_idle("hold end");

        // reset in STEP at idx 2: IDLE next edge, no done pulse
        @(negedge clk);
        host.start   = 1'b1;
        host.mode    = MODE_FIB;
        host.n_terms = CNT_W'(6);
        check_run("rst", MODE_FIB, 6, 1'b0, 4);
        host.start = 1'b0;
        reset      = 1'b1;
        #1;
        chk("rst cycle dp_reset", 32'(dp_reset), 32'd1);
        chk("rst cycle done", 32'(host.done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) check_idle($sformatf("rst after%0d", i));
        do_run("post-rst", MODE_FIB, 3);
        chk("post-rst term count", 32'(vcnt), 32'd3);

`ifdef SEQ_RUN_PAUSE_EN
        // pause for 3 cycles while term 2 is pending, then resume
        @(negedge clk);
        host.start   = 1'b1;
        host.mode    = MODE_FIB;
        host.n_terms = CNT_W'(5);
        check_run("pause", MODE_FIB, 5, 1'b0, 3);
        host.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host.pause = 1'b1;
            #1;
            chk($sformatf("pause%0d valid", i), 32'(host.term_valid), 32'd0);
            chk($sformatf("pause%0d seq_out", i), 32'(seq_out), 32'd2);
            chk($sformatf("pause%0d loads", i), 32'({r1_ld, r0_ld}), 32'd0);
            chk($sformatf("pause%0d busy", i), 32'(host.busy), 32'd1);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            host.pause = 1'b0;
            #1;
            chk($sformatf("resume k%0d valid", k), 32'(host.term_valid), 32'd1);
            chk($sformatf("resume k%0d idx", k), 32'(host.term_idx), 32'(k));
            chk($sformatf("resume k%0d seq_out", k), 32'(seq_out), 32'(ref_term(MODE_FIB, k)));
        end
        @(negedge clk);
        chk("pause run done", 32'(host.done), 32'd1);
        check_idle("pause end");
`endif

        for (int r = 0; r < 40; r++) begin
            logic m;
            int   n;
            int   gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) check_idle($sformatf("rnd%0d gap", r));
            m = 1'($urandom);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            do_run($sformatf("rnd%0d", r), m, n);
            chk($sformatf("rnd%0d term count", r), 32'(vcnt), 32'(n));
        end
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
